// File: rtl/sm83_pkg.sv
// Shared types and constants for the SM83 interrupt controller slice.
package sm83_pkg;

  typedef logic [15:0] addr_t;
  typedef logic [7:0]  data_t;

  typedef enum logic [2:0] {
    IRQ_VBLANK = 3'd0,
    IRQ_STAT   = 3'd1,
    IRQ_TIMER  = 3'd2,
    IRQ_SERIAL = 3'd3,
    IRQ_JOYPAD = 3'd4
  } irq_src_t;

  typedef enum logic [1:0] {
    INT_IDLE,
    INT_DISPATCH,
    INT_RESOLVE
  } int_state_t;

  localparam addr_t IF_ADDR_DEF  = 16'hFF0F;
  localparam addr_t IE_ADDR_DEF  = 16'hFFFF;
  localparam addr_t INT_VEC_BASE = 16'h0040;

  // Restart vectors are spaced 8 bytes apart starting at the base.
  function automatic addr_t int_vec_addr(input addr_t base, input irq_src_t idx);
    return base + {10'd0, idx, 3'b000};
  endfunction

endpackage

// File: rtl/sm83_int_prio.sv
// Lowest-index-wins priority encoder over the five interrupt sources.
module sm83_int_prio
  import sm83_pkg::*;
(
  input  logic [4:0] req,
  output logic       hit,
  output irq_src_t   idx
);

  always_comb begin
    hit = |req;
    idx = IRQ_VBLANK;
    for (int i = 4; i >= 0; i--) begin
      if (req[i]) idx = irq_src_t'(3'(i));
    end
  end

endmodule

// File: rtl/sm83_int_ctrl.sv
// Interrupt controller: IF/IE registers, bus decode and the core dispatch handshake.
module sm83_int_ctrl
  import sm83_pkg::*;
#(
  parameter addr_t IF_ADDR  = IF_ADDR_DEF,
  parameter addr_t IE_ADDR  = IE_ADDR_DEF,
  parameter addr_t VEC_BASE = INT_VEC_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  irq_src,
  input  addr_t       bus_addr,
  input  data_t       bus_wdata,
  input  logic        bus_wr,
  input  logic        bus_rd,
  output data_t       bus_rdata,
  output logic        bus_rhit,
  input  logic        ime,
  output logic        int_pending,
  output logic        int_req,
  input  logic        int_take,
  input  logic        int_vec_req,
  output addr_t       int_vec,
  output logic        int_vec_valid,
  output logic        busy
);

  int_state_t state_q, state_d;
  logic [4:0] if_q, if_d;
  data_t      ie_q;
  logic [4:0] active;
  logic       hit;
  irq_src_t   idx;
  logic       ie_wr, if_wr, rd_ie, rd_if, resolve;

  assign active = ie_q[4:0] & if_q;

  sm83_int_prio u_prio (
    .req (active),
    .hit (hit),
    .idx (idx)
  );

  assign ie_wr   = bus_wr && (bus_addr == IE_ADDR);
  assign if_wr   = bus_wr && (bus_addr == IF_ADDR) && !ie_wr;
  assign rd_ie   = bus_rd && (bus_addr == IE_ADDR);
  assign rd_if   = bus_rd && (bus_addr == IF_ADDR) && !rd_ie;
  assign resolve = (state_q == INT_DISPATCH) && int_vec_req;

  assign int_pending   = |active;
  assign int_req       = int_pending && ime && (state_q == INT_IDLE);
  assign int_vec_valid = (state_q == INT_RESOLVE);
  assign busy          = (state_q != INT_IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      INT_IDLE:     if (int_take && int_req) state_d = INT_DISPATCH;
      INT_DISPATCH: if (int_vec_req)         state_d = INT_RESOLVE;
      INT_RESOLVE:                           state_d = INT_IDLE;
      default:                               state_d = INT_IDLE;
    endcase
  end

  // Write replaces, resolve clears, then new requests set: a pulse is never lost.
  always_comb begin
    if_d = if_q;
    if (if_wr) if_d = bus_wdata[4:0];
    if (resolve && hit) if_d[idx] = 1'b0;
    if_d = if_d | irq_src;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= INT_IDLE;
      if_q      <= '0;
      ie_q      <= '0;
      bus_rdata <= '0;
      bus_rhit  <= 1'b0;
      int_vec   <= '0;
    end else begin
      state_q   <= state_d;
      if_q      <= if_d;
      if (ie_wr) ie_q <= bus_wdata;
      bus_rhit  <= rd_ie || rd_if;
      bus_rdata <= rd_ie ? ie_q : (rd_if ? {3'b111, if_q} : 8'h00);
      // Winner is recomputed at the vector sample so late IE/IF writes count.
      if (resolve) int_vec <= hit ? int_vec_addr(VEC_BASE, idx) : 16'h0000;
    end
  end

endmodule

// File: tb/tb_sm83_int_ctrl.sv
// Self-checking bench for sm83_int_ctrl: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_sm83_int_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  irq_src = '0;
  logic [15:0] bus_addr = '0;
  logic [7:0]  bus_wdata = '0;
  logic        bus_wr = 1'b0, bus_rd = 1'b0, ime = 1'b0;
  logic        int_take = 1'b0, int_vec_req = 1'b0;
  logic [7:0]  bus_rdata;
  logic        bus_rhit, int_pending, int_req, int_vec_valid, busy;
  logic [15:0] int_vec;

  int checks = 0;
  int errors = 0;

  // Model state: register contents, dispatch phase flags, expected registered outputs.
  logic [4:0]  m_if = '0;
  logic [7:0]  m_ie = '0;
  bit          m_disp = 0, m_resv = 0;
  logic [15:0] m_vec = '0;
  logic [7:0]  m_rdata = '0;
  bit          m_rhit = 0;

  sm83_int_ctrl dut (
    .clk(clk), .rst(rst), .irq_src(irq_src),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wr(bus_wr), .bus_rd(bus_rd),
    .bus_rdata(bus_rdata), .bus_rhit(bus_rhit), .ime(ime),
    .int_pending(int_pending), .int_req(int_req), .int_take(int_take),
    .int_vec_req(int_vec_req), .int_vec(int_vec), .int_vec_valid(int_vec_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [4:0] v);
    for (int i = 0; i < 5; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Advance the model across one rising edge using the inputs presented to it.
  task automatic model_edge();
    logic [4:0] pend, nif;
    bit         req;
    int         n;
    if (rst) begin
      m_if = '0; m_ie = '0; m_disp = 0; m_resv = 0;
      m_vec = '0; m_rdata = '0; m_rhit = 0;
      return;
    end
    pend   = m_ie[4:0] & m_if;
    req    = (pend != 0) && ime && !m_disp && !m_resv;
    m_rhit = bus_rd && (bus_addr == 16'hFFFF || bus_addr == 16'hFF0F);
    if (!bus_rd)                  m_rdata = 8'h00;
    else if (bus_addr == 16'hFFFF) m_rdata = m_ie;
    else if (bus_addr == 16'hFF0F) m_rdata = {3'b111, m_if};
    else                           m_rdata = 8'h00;
    nif = m_if;
    if (bus_wr && bus_addr == 16'hFF0F) nif = bus_wdata[4:0];
    if (m_disp && int_vec_req) begin
      n = lowest(pend);
      if (n >= 0) begin
        nif[n] = 1'b0;
        m_vec  = 16'h0040 + 16'(8 * n);
      end else begin
        m_vec = 16'h0000;
      end
    end
    m_if = nif | irq_src;
    if (bus_wr && bus_addr == 16'hFFFF) m_ie = bus_wdata;
    if (m_resv) m_resv = 0;
    else if (m_disp) begin
      if (int_vec_req) begin m_disp = 0; m_resv = 1; end
    end else if (int_take && req) m_disp = 1;
  endtask

  task automatic check_all();
    logic pend;
    pend = |(m_ie[4:0] & m_if);
    cmp("int_pending",   16'(int_pending),   16'(pend));
    cmp("int_req",       16'(int_req),       16'(pend && ime && !m_disp && !m_resv));
    cmp("int_vec_valid", 16'(int_vec_valid), 16'(m_resv));
    cmp("busy",          16'(busy),          16'(m_disp || m_resv));
    cmp("int_vec",       int_vec,            m_vec);
    cmp("bus_rdata",     16'(bus_rdata),     16'(m_rdata));
    cmp("bus_rhit",      16'(bus_rhit),      16'(m_rhit));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic clr();
    irq_src = '0; bus_wr = 0; bus_rd = 0; int_take = 0; int_vec_req = 0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus_addr = a; bus_wdata = d; bus_wr = 1; step(); clr();
  endtask

  task automatic rd_chk(input string name, input logic [15:0] a, input logic [7:0] exp);
    bus_addr = a; bus_rd = 1; step(); clr();
    cmp(name, 16'(bus_rdata), 16'(exp));
  endtask

  task automatic take();
    int_take = 1; step(); clr();
  endtask

  task automatic vreq();
    int_vec_req = 1; step(); clr();
  endtask

  initial begin
    rst = 1; step(); step(); rst = 0;
    cmp("rst_busy", 16'(busy), 16'd0);
    cmp("rst_vec", int_vec, 16'h0000);
    cmp("rst_pend", 16'(int_pending), 16'd0);
    cmp("rst_valid", 16'(int_vec_valid), 16'd0);

    // 1: timer interrupt end to end
    ime = 1;
    wr(16'hFFFF, 8'h04);
    irq_src = 5'b00100; step(); clr();
    cmp("t1_pend", 16'(int_pending), 16'd1);
    cmp("t1_req", 16'(int_req), 16'd1);
    take();
    cmp("t1_busy", 16'(busy), 16'd1);
    cmp("t1_req_blocked", 16'(int_req), 16'd0);
    vreq();
    cmp("t1_valid", 16'(int_vec_valid), 16'd1);
    cmp("t1_vec", int_vec, 16'h0050);
    step();
    cmp("t1_valid_drop", 16'(int_vec_valid), 16'd0);
    rd_chk("t1_if", 16'hFF0F, 8'hE0);

    // 2: two pending, lowest index first
    wr(16'hFFFF, 8'h1F);
    wr(16'hFF0F, 8'h12);
    take(); vreq();
    cmp("t2_vec1", int_vec, 16'h0048);
    step();
    rd_chk("t2_if", 16'hFF0F, 8'hF0);
    take(); vreq();
    cmp("t2_vec2", int_vec, 16'h0060);
    step();

    // 3: IE cleared during dispatch cancels it
    wr(16'hFFFF, 8'h01);
    wr(16'hFF0F, 8'h01);
    take();
    wr(16'hFFFF, 8'h00);
    vreq();
    cmp("t3_vec", int_vec, 16'h0000);
    cmp("t3_valid", 16'(int_vec_valid), 16'd1);
    step();
    rd_chk("t3_if", 16'hFF0F, 8'hE1);

    // 4: ime low
    ime = 0;
    wr(16'hFF0F, 8'h00);
    wr(16'hFFFF, 8'h01);
    irq_src = 5'b00001; step(); clr();
    cmp("t4_pend", 16'(int_pending), 16'd1);
    cmp("t4_req", 16'(int_req), 16'd0);
    take();
    cmp("t4_busy", 16'(busy), 16'd0);

    // 5: set beats a same-cycle write; IE keeps all 8 bits; unmapped read misses
    bus_addr = 16'hFF0F; bus_wdata = 8'h00; bus_wr = 1; irq_src = 5'b01000; step(); clr();
    rd_chk("t5_if", 16'hFF0F, 8'hE8);
    wr(16'hFFFF, 8'hA5);
    rd_chk("t5_ie", 16'hFFFF, 8'hA5);
    rd_chk("t5_miss_data", 16'h1234, 8'h00);
    cmp("t5_miss_hit", 16'(bus_rhit), 16'd0);

    // 6: reset mid-dispatch
    ime = 1;
    wr(16'hFF0F, 8'h00);
    wr(16'hFFFF, 8'h01);
    irq_src = 5'b00001; step(); clr();
    take();
    cmp("t6_busy_pre", 16'(busy), 16'd1);
    rst = 1; step(); rst = 0;
    cmp("t6_busy", 16'(busy), 16'd0);
    cmp("t6_valid", 16'(int_vec_valid), 16'd0);
    step();
    cmp("t6_valid2", 16'(int_vec_valid), 16'd0);
    rd_chk("t6_if", 16'hFF0F, 8'hE0);

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      rst       = ($urandom_range(0, 599) == 0);
      ime       = ($urandom_range(0, 7) != 0);
      irq_src   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
      bus_wr    = ($urandom_range(0, 9) == 0);
      bus_rd    = !bus_wr && ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 3))
        0:       bus_addr = 16'hFF0F;
        1:       bus_addr = 16'hFFFF;
        2:       bus_addr = 16'($urandom);
        default: bus_addr = 16'hFF0F;
      endcase
      bus_wdata   = 8'($urandom);
      int_take    = ($urandom_range(0, 3) == 0);
      int_vec_req = ($urandom_range(0, 2) == 0);
      step();
    end
    clr(); rst = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
